alu_flag_stage: RTL and testbench

//   Registered output stage sitting directly downstream of the N-bit adder/ALU.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_cond_eval.sv | 42 ++++
 rtl/alu_flag_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_flag_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU output/flags logic.
//   flags_t      : packed {n,z,c,v} condition flags.
//   cond_e       : 4-bit ARM-style condition code (EQ..NV).
//   skid_state_e : occupancy of the 2-entry output skid buffer.
//   FLAG_*       : bit positions of each flag in a raw 4-bit {N,Z,C,V} vector.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// ---------------------------------------------------------------------------
// alu_cond_eval
//   Pure combinational evaluation of an ARM condition code against NZCV flags.
//   Shared with the branch unit.
//   flags_i : flags to test
//   cond_i  : condition code
//   pass_o  : 1 when the condition holds
// ---------------------------------------------------------------------------
module alu_cond_eval
   import alu_pkg::*;
(
   input  flags_t flags_i,
   input  cond_e  cond_i,
   output logic   pass_o
);

   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = flags_i.z;
         COND_NE: pass_o = !flags_i.z;
         COND_CS: pass_o = flags_i.c;
         COND_CC: pass_o = !flags_i.c;
         COND_MI: pass_o = flags_i.n;
         COND_PL: pass_o = !flags_i.n;
         COND_VS: pass_o = flags_i.v;
         COND_VC: pass_o = !flags_i.v;
         COND_HI: pass_o = flags_i.c && !flags_i.z;
         COND_LS: pass_o = !flags_i.c || flags_i.z;
         COND_GE: pass_o = (flags_i.n == flags_i.v);
         COND_LT: pass_o = (flags_i.n != flags_i.v);
         COND_GT: pass_o = !flags_i.z && (flags_i.n == flags_i.v);
         COND_LE: pass_o = flags_i.z || (flags_i.n != flags_i.v);
         COND_AL: pass_o = 1'b1;
         COND_NV: pass_o = 1'b0;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_flag_stage.sv
// ---------------------------------------------------------------------------
// alu_flag_stage
//   Registered output stage behind the adder/ALU. Result beats (sum + NZCV +
//   set) pass through a 2-entry valid/ready skid buffer; a retiring beat with
//   set=1 commits its flags to the architectural NZCV register and, if V=1,
//   bumps a saturating overflow counter. A condition code is evaluated
//   against the architectural flags.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     in_valid/in_ready           upstream handshake (in_ready is registered)
//     in_sum/in_flags/in_set      upstream beat payload
//     out_valid/out_ready         downstream handshake
//     out_sum/out_flags           head beat payload
//     flags_q                     architectural NZCV register
//     cond_sel/cond_pass          condition code and its result on flags_q
//     ovf_clr/ovf_cnt             overflow counter clear and value
// ---------------------------------------------------------------------------
module alu_flag_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [3:0]       in_flags,
   input  logic             in_set,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [3:0]       out_flags,
   output logic [3:0]       flags_q,
   input  logic [3:0]       cond_sel,
   output logic             cond_pass,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] ovf_cnt
);

   skid_state_e      state_q, state_d;
   logic             in_ready_q, in_ready_d;

   logic [WIDTH-1:0] head_sum_q, head_sum_d;
   flags_t           head_flags_q, head_flags_d;
   logic             head_set_q, head_set_d;

   logic [WIDTH-1:0] skid_sum_q, skid_sum_d;
   flags_t           skid_flags_q, skid_flags_d;
   logic             skid_set_q, skid_set_d;

   flags_t           arch_flags_q, arch_flags_d;
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   flags_t           in_flags_s;
   logic             accept, retire, ovf_inc;

   assign in_flags_s = '{n: in_flags[FLAG_N], z: in_flags[FLAG_Z],
                         c: in_flags[FLAG_C], v: in_flags[FLAG_V]};

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready_q;
   assign retire    = out_valid && out_ready;

   // Skid buffer: head holds the oldest beat; skid only fills when the head
   // is stalled, so in_ready can be a flop instead of a path from out_ready.
   always_comb begin
      state_d      = state_q;
      head_sum_d   = head_sum_q;
      head_flags_d = head_flags_q;
      head_set_d   = head_set_q;
      skid_sum_d   = skid_sum_q;
      skid_flags_d = skid_flags_q;
      skid_set_d   = skid_set_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d      = ST_ONE;
               head_sum_d   = in_sum;
               head_flags_d = in_flags_s;
               head_set_d   = in_set;
            end
         end
         ST_ONE: begin
            if (accept && retire) begin
               head_sum_d   = in_sum;
               head_flags_d = in_flags_s;
               head_set_d   = in_set;
            end else if (accept) begin
               state_d      = ST_FULL;
               skid_sum_d   = in_sum;
               skid_flags_d = in_flags_s;
               skid_set_d   = in_set;
            end else if (retire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (retire) begin
               state_d      = ST_ONE;
               head_sum_d   = skid_sum_q;
               head_flags_d = skid_flags_q;
               head_set_d   = skid_set_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_FULL);
   end

   // Architectural flags and overflow counter move only on retire, never on
   // accept; a clear in the same cycle as an increment wins.
   assign ovf_inc = retire && head_set_q && head_flags_q.v;

   always_comb begin
      arch_flags_d = arch_flags_q;
      if (retire && head_set_q) begin
         arch_flags_d = head_flags_q;
      end
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr) begin
         ovf_cnt_d = '0;
      end else if (ovf_inc && !(&ovf_cnt_q)) begin
         ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: the payload registers are reset too, because out_sum/out_flags
   // must read zero out of reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         in_ready_q   <= 1'b1;
         head_sum_q   <= '0;
         head_flags_q <= '0;
         head_set_q   <= 1'b0;
         skid_sum_q   <= '0;
         skid_flags_q <= '0;
         skid_set_q   <= 1'b0;
         arch_flags_q <= '0;
         ovf_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         head_sum_q   <= head_sum_d;
         head_flags_q <= head_flags_d;
         head_set_q   <= head_set_d;
         skid_sum_q   <= skid_sum_d;
         skid_flags_q <= skid_flags_d;
         skid_set_q   <= skid_set_d;
         arch_flags_q <= arch_flags_d;
         ovf_cnt_q    <= ovf_cnt_d;
      end
   end

   alu_cond_eval u_cond_eval (
      .flags_i (arch_flags_q),
      .cond_i  (cond_e'(cond_sel)),
      .pass_o  (cond_pass)
   );

   assign in_ready  = in_ready_q;
   assign out_sum   = head_sum_q;
   assign out_flags = head_flags_q;
   assign flags_q   = arch_flags_q;
   assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_stage
//   Self-checking bench for alu_flag_stage (WIDTH=4, CNT_W=2). A queue-based
//   reference model holds in-flight beats, the flags register and the
//   overflow count; each scenario task compares the DUT against it inline.
// ---------------------------------------------------------------------------
module tb_alu_flag_stage;
   import alu_pkg::*;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [3:0]       in_flags;
   logic             in_set;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [3:0]       out_flags;
   logic [3:0]       flags_q;
   logic [3:0]       cond_sel;
   logic             cond_pass;
   logic             ovf_clr;
   logic [CNT_W-1:0] ovf_cnt;

   alu_flag_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_flags  (in_flags),
      .in_set    (in_set),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_flags (out_flags),
      .flags_q   (flags_q),
      .cond_sel  (cond_sel),
      .cond_pass (cond_pass),
      .ovf_clr   (ovf_clr),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic [3:0]       flags;
      logic             set;
   } beat_t;

   beat_t      q[$];
   logic [3:0] flags_m;
   int         cnt_m;
   int         errors = 0;
   int         checks = 0;

   // ARM conditions come in pairs: even code = base test, odd code = its
   // inverse. Base of pair 7 is "always", so its inverse is "never".
   function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cf, v, base;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_exp();
      return CNT_W'(cnt_m);
   endfunction

   // Advance one clock with the inputs currently driven; update the model.
   task automatic tick();
      bit    acc, ret;
      beat_t b;
      acc = in_valid && (q.size() < 2);
      ret = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (ret) begin
         b = q.pop_front();
         if (b.set) flags_m = b.flags;
         if (b.set && b.flags[0] && cnt_m < CNT_MAX) cnt_m++;
      end
      if (ovf_clr) cnt_m = 0;
      if (acc) begin
         b.sum   = in_sum;
         b.flags = in_flags;
         b.set   = in_set;
         q.push_back(b);
      end
      @(negedge clk);
   endtask

   // Push one beat through with out_ready high so its flags commit.
   task automatic load_flags(input logic [3:0] f);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sum    = 4'h0;
      in_flags  = f;
      in_set    = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_flags = '0; in_set = 1'b0;
      out_ready = 1'b0; cond_sel = '0; ovf_clr = 1'b0;
      q.delete(); flags_m = '0; cnt_m = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags_q !== 4'h0 || ovf_cnt !== '0
          || out_sum !== '0 || out_flags !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b ready=%b flags=%h cnt=%0d sum=%h oflags=%h, expected 0 1 0 0 0 0",
                  out_valid, in_ready, flags_q, ovf_cnt, out_sum, out_flags);
      end
      // Commit non-zero flags and a count so reset has something to clear.
      load_flags(4'b1001);
      checks++;
      if (flags_q !== 4'b1001 || ovf_cnt !== cnt_exp()) begin
         errors++;
         $display("FAIL reset_preload: got flags=%h cnt=%0d expected %h %0d", flags_q, ovf_cnt, 4'b1001, cnt_exp());
      end
      out_ready = 1'b0;
      in_valid  = 1'b1; in_set = 1'b1; in_flags = 4'b0001;
      in_sum = 4'hA; tick();
      in_sum = 4'hB; tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 4'hA) begin
         errors++;
         $display("FAIL reset_held: got valid=%b ready=%b sum=%h expected 1 0 a", out_valid, in_ready, out_sum);
      end
      #2 rst_n = 1'b0;
      q.delete(); flags_m = '0; cnt_m = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || flags_q !== 4'h0 || ovf_cnt !== '0) begin
         errors++;
         $display("FAIL reset_async: got valid=%b flags=%h cnt=%0d expected 0 0 0", out_valid, flags_q, ovf_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_streaming();
      out_ready = 1'b1; in_flags = 4'h0; in_set = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_sum   = WIDTH'(i);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== WIDTH'(i) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_beat%0d: got valid=%b sum=%h ready=%b expected 1 %h 1",
                     i, out_valid, out_sum, in_ready, WIDTH'(i));
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] got[$];
      logic [WIDTH-1:0] exp_sums[3];
      bit               sent3;
      exp_sums[0] = 4'h7; exp_sums[1] = 4'h8; exp_sums[2] = 4'h9;
      out_ready = 1'b0; in_flags = 4'h0; in_set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_sum   = exp_sums[i];
         tick();
         checks++;
         if (in_ready !== (i == 0) || out_sum !== 4'h7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill%0d: got ready=%b sum=%h valid=%b expected %b 7 1",
                     i, in_ready, out_sum, out_valid, (i == 0));
         end
      end
      // Third beat is still presented (stalled); release downstream.
      out_ready = 1'b1;
      sent3 = 1'b0;
      for (int c = 0; c < 10 && got.size() < 3; c++) begin
         if (out_valid) got.push_back(out_sum);
         if (in_valid && in_ready) sent3 = 1'b1;
         tick();
         if (sent3) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL bp_count: got %0d beats expected 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp_sums[i]) begin
               errors++;
               $display("FAIL bp_order%0d: got %h expected %h", i, got[i], exp_sums[i]);
            end
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_empty: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_flags();
      out_ready = 1'b1;
      in_valid = 1'b1; in_sum = 4'h0; in_flags = 4'b0100; in_set = 1'b1;
      tick();
      checks++;
      if (flags_q !== 4'h0 || out_flags !== 4'b0100) begin
         errors++;
         $display("FAIL flags_no_accept_update: got flags=%h oflags=%h expected 0 4", flags_q, out_flags);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (flags_q !== 4'b0100) begin
         errors++;
         $display("FAIL flags_commit: got %h expected 4", flags_q);
      end
      cond_sel = COND_EQ; #1;
      checks++;
      if (cond_pass !== 1'b1) begin
         errors++;
         $display("FAIL flags_eq: got %b expected 1", cond_pass);
      end
      cond_sel = COND_NE; #1;
      checks++;
      if (cond_pass !== 1'b0) begin
         errors++;
         $display("FAIL flags_ne: got %b expected 0", cond_pass);
      end
      in_valid = 1'b1; in_sum = 4'h3; in_flags = 4'b1000; in_set = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_flags !== 4'b1000) begin
         errors++;
         $display("FAIL flags_beat: got %h expected 8", out_flags);
      end
      tick();
      checks++;
      if (flags_q !== 4'b0100) begin
         errors++;
         $display("FAIL flags_set0_kept: got %h expected 4", flags_q);
      end
   endtask

   task automatic test_conditions();
      load_flags(4'b1001);
      cond_sel = COND_GE; #1;
      checks++;
      if (cond_pass !== 1'b1) begin errors++; $display("FAIL cond_ge: got %b expected 1", cond_pass); end
      cond_sel = COND_LT; #1;
      checks++;
      if (cond_pass !== 1'b0) begin errors++; $display("FAIL cond_lt: got %b expected 0", cond_pass); end
      cond_sel = COND_GT; #1;
      checks++;
      if (cond_pass !== 1'b1) begin errors++; $display("FAIL cond_gt: got %b expected 1", cond_pass); end
      load_flags(4'b0010);
      cond_sel = COND_HI; #1;
      checks++;
      if (cond_pass !== 1'b1) begin errors++; $display("FAIL cond_hi: got %b expected 1", cond_pass); end
      cond_sel = COND_LS; #1;
      checks++;
      if (cond_pass !== 1'b0) begin errors++; $display("FAIL cond_ls: got %b expected 0", cond_pass); end
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         checks++;
         if (flags_q !== 4'(f)) begin
            errors++;
            $display("FAIL cond_load: got %h expected %h", flags_q, 4'(f));
         end
         for (int c = 0; c < 16; c++) begin
            cond_sel = 4'(c); #1;
            checks++;
            if (cond_pass !== ref_cond(4'(f), 4'(c))) begin
               errors++;
               $display("FAIL cond_f%h_c%h: got %b expected %b", 4'(f), 4'(c), cond_pass, ref_cond(4'(f), 4'(c)));
            end
         end
      end
   endtask

   task automatic test_counter();
      ovf_clr = 1'b1; in_valid = 1'b0;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_cnt !== '0) begin errors++; $display("FAIL cnt_clear: got %0d expected 0", ovf_cnt); end
      out_ready = 1'b1; in_set = 1'b0; in_flags = 4'b0001; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (ovf_cnt !== '0) begin errors++; $display("FAIL cnt_set0: got %0d expected 0", ovf_cnt); end
      in_set = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (ovf_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d expected 3", ovf_cnt); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_cnt !== '0 || q.size() != 0) begin
         errors++;
         $display("FAIL cnt_clr_wins: got %0d expected 0", ovf_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sum    = WIDTH'($urandom);
         in_flags  = 4'($urandom);
         in_set    = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 9) < 6);
         cond_sel  = 4'($urandom);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL rand_hs%0d: got valid=%b ready=%b expected %b %b",
                     i, out_valid, in_ready, (q.size() > 0), (q.size() < 2));
         end
         if (q.size() > 0) begin
            checks++;
            if (out_sum !== q[0].sum || out_flags !== q[0].flags) begin
               errors++;
               $display("FAIL rand_head%0d: got sum=%h flags=%h expected %h %h",
                        i, out_sum, out_flags, q[0].sum, q[0].flags);
            end
         end
         checks++;
         if (flags_q !== flags_m || ovf_cnt !== cnt_exp() || cond_pass !== ref_cond(flags_m, cond_sel)) begin
            errors++;
            $display("FAIL rand_state%0d: got flags=%h cnt=%0d pass=%b expected %h %0d %b",
                     i, flags_q, ovf_cnt, cond_pass, flags_m, cnt_exp(), ref_cond(flags_m, cond_sel));
         end
      end
      in_valid = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flags();
      test_conditions();
      test_counter();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
